// File: rtl/pid_pkg.sv
// Shared definitions for the PID output stage.
// Contents: effort/counter widths, signed effort type, dead-time FSM states,
// and the |u| -> PWM magnitude helper with clamping.
package pid_pkg;

  localparam int unsigned U_W       = 6;
  localparam int unsigned PWM_CNT_W = 5;

  typedef logic signed [U_W-1:0] effort_t;

  typedef enum logic {
    DT_IDLE  = 1'b0,
    DT_BLANK = 1'b1
  } dt_state_t;

  // Most negative effort; its magnitude does not fit the PWM counter.
  localparam effort_t U_MIN = effort_t'({1'b1, {(U_W-1){1'b0}}});

  // |e| in U_W bits, clamped to the counter range. Since U_W == PWM_CNT_W+1,
  // the only out-of-range magnitude is |U_MIN|, flagged by the top bit.
  function automatic logic [PWM_CNT_W-1:0] effort_mag(input effort_t e);
    logic [U_W-1:0] a;
    a = e[U_W-1] ? (~e + 1'b1) : e;
    return a[U_W-1] ? {PWM_CNT_W{1'b1}} : a[PWM_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Prescaler plus 5-bit PWM period counter.
// Ports:
//   clk, rst_n (sync, active-low), ena (freezes counting when low)
//   tick     : one PWM count elapsed this cycle
//   boundary : tick on the last count of a period (cnt == 31)
//   cnt      : current PWM count, 0..31
module pwm_period_counter
  import pid_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  output logic                 tick,
  output logic                 boundary,
  output logic [PWM_CNT_W-1:0] cnt
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;

  // With PRESCALE == 1, pre stays at 0 and tick follows ena.
  assign tick     = ena && (pre == PRE_MAX);
  assign boundary = tick && (cnt == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      if (ena) begin
        pre <= tick ? '0 : pre + 1'b1;
      end
      if (boundary) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pid_pwm_driver.sv
// Sign/magnitude PWM driver for an H-bridge, fed by the PID effort u.
// Duty, direction and saturation flag are latched only at period boundaries,
// so pwm_out never glitches mid-period.
// Parameter: PRESCALE (1..256) clocks per PWM count; period = 32*PRESCALE clocks.
// Ports:
//   clk, rst_n (sync, active-low), ena (low freezes the block, forces outputs low)
//   u            : 6-bit two's-complement effort, sampled at boundaries
//   pwm_out      : registered PWM magnitude
//   dir_out      : 1 when the latched effort is negative
//   period_start : one-cycle pulse in the first cycle of each period
//   sat          : latched effort was -32 (clamped to duty 31)
// Build option: define PWM_DEADTIME_EN to insert one fully-low period on
// every direction reversal with non-zero magnitude.
module pid_pwm_driver
  import pid_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [U_W-1:0] u,
  output logic           pwm_out,
  output logic           dir_out,
  output logic           period_start,
  output logic           sat
);

  logic                 tick;
  logic                 boundary;
  logic [PWM_CNT_W-1:0] cnt;
  logic [PWM_CNT_W-1:0] cnt_next;
  logic [PWM_CNT_W-1:0] mag;
  logic [PWM_CNT_W-1:0] duty_r;
  logic [PWM_CNT_W-1:0] duty_next;
  logic                 dir_r;
  logic                 dir_next;
  logic                 sat_r;
  logic                 sat_next;
  effort_t              u_s;

`ifdef PWM_DEADTIME_EN
  dt_state_t state;
  dt_state_t state_next;
`endif

  pwm_period_counter #(
    .PRESCALE(PRESCALE)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .tick    (tick),
    .boundary(boundary),
    .cnt     (cnt)
  );

  assign u_s = effort_t'(u);
  assign mag = effort_mag(u_s);

  // Count value after this edge; pwm_out is registered against it so the
  // output lines up with cnt rather than lagging by a cycle.
  assign cnt_next = boundary ? '0 : (tick ? cnt + 1'b1 : cnt);

  always_comb begin
    duty_next = duty_r;
    dir_next  = dir_r;
    sat_next  = sat_r;
`ifdef PWM_DEADTIME_EN
    state_next = state;
    if (boundary) begin
      if (state == DT_IDLE && u_s[U_W-1] != dir_r && mag != '0) begin
        // Reversal: flip direction now but hold the bridge off for a period.
        state_next = DT_BLANK;
        dir_next   = u_s[U_W-1];
        duty_next  = '0;
        sat_next   = 1'b0;
      end else begin
        state_next = DT_IDLE;
        duty_next  = mag;
        dir_next   = u_s[U_W-1];
        sat_next   = (u_s == U_MIN);
      end
    end
`else
    if (boundary) begin
      duty_next = mag;
      dir_next  = u_s[U_W-1];
      sat_next  = (u_s == U_MIN);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_r       <= '0;
      dir_r        <= 1'b0;
      sat_r        <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
`ifdef PWM_DEADTIME_EN
      state        <= DT_IDLE;
`endif
    end else begin
      duty_r       <= duty_next;
      dir_r        <= dir_next;
      sat_r        <= sat_next;
      pwm_out      <= ena && (cnt_next < duty_next);
      period_start <= boundary;
`ifdef PWM_DEADTIME_EN
      state        <= state_next;
`endif
    end
  end

  assign dir_out = dir_r;
  assign sat     = sat_r;

endmodule

// File: tb/tb_pid_pwm_driver.sv
module tb_pid_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n, ena, rst4_n, ena4;
  logic [5:0] u, u4;
  logic       pwm, dir, ps, sat;
  logic       pwm4, dir4, ps4, sat4;

  always #5 clk = ~clk;

  pid_pwm_driver #(.PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .u(u),
    .pwm_out(pwm), .dir_out(dir), .period_start(ps), .sat(sat)
  );

  pid_pwm_driver #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .ena(ena4), .u(u4),
    .pwm_out(pwm4), .dir_out(dir4), .period_start(ps4), .sat(sat4)
  );

  typedef struct { int duty; int dir; int sat; } exp_t;
  typedef struct { logic [5:0] u; int off; int duty; int dir; int sat; } vec_t;

  exp_t sb[$];
  vec_t tab[9];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_ps(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ps !== 1'b1 && n < 100);
    if (ps !== 1'b1) chk(name, 0, 1);
  endtask

  task automatic wait_ps4(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ps4 !== 1'b1 && n < 300);
    if (ps4 !== 1'b1) chk(name, 0, 1);
  endtask

  // Monitor: each period_start pops the expectation for that period and
  // checks the 32 clocks that make it up.
  initial begin : monitor
    exp_t e;
    int   hi, shape_bad, dir_bad, sat_bad, ps_bad, pidx;
    pidx = 0;
    forever begin
      @(negedge clk);
      if (mon_en && ps === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_period", 1, 0);
        end else begin
          e = sb.pop_front();
          hi = 0; shape_bad = 0; dir_bad = 0; sat_bad = 0; ps_bad = 0;
          for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            if (pwm === 1'b1) hi++;
            if (pwm !== ((k < e.duty) ? 1'b1 : 1'b0)) shape_bad++;
            if (dir !== e.dir[0]) dir_bad++;
            if (sat !== e.sat[0]) sat_bad++;
            if (ps !== ((k == 0) ? 1'b1 : 1'b0)) ps_bad++;
          end
          chk($sformatf("p%0d_high_clocks", pidx), hi, e.duty);
          chk($sformatf("p%0d_pwm_shape_bad_clocks", pidx), shape_bad, 0);
          chk($sformatf("p%0d_dir_bad_clocks", pidx), dir_bad, 0);
          chk($sformatf("p%0d_sat_bad_clocks", pidx), sat_bad, 0);
          chk($sformatf("p%0d_period_start_bad_clocks", pidx), ps_bad, 0);
          pidx++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int hi, psn;
`ifdef PWM_DEADTIME_EN
    tab[0] = '{6'h08,  0,  8, 0, 0};
    tab[1] = '{6'h38,  3,  0, 1, 0};  // -8: blank period first
    tab[2] = '{6'h38,  0,  8, 1, 0};
    tab[3] = '{6'h00,  0,  0, 0, 0};  // zero never blanks
    tab[4] = '{6'h03,  0,  3, 0, 0};
    tab[5] = '{6'h20,  0,  0, 1, 0};  // -32: blank
    tab[6] = '{6'h20,  0, 31, 1, 1};
    tab[7] = '{6'h04,  0,  0, 0, 0};  // +4: blank
    tab[8] = '{6'h14, 10, 20, 0, 0};
`else
    tab[0] = '{6'h08,  0,  8, 0, 0};
    tab[1] = '{6'h20,  3, 31, 1, 1};  // -32 clamps
    tab[2] = '{6'h3B,  0,  5, 1, 0};  // -5
    tab[3] = '{6'h04,  0,  4, 0, 0};
    tab[4] = '{6'h14, 10, 20, 0, 0};  // change at cnt 10, current stays 4
    tab[5] = '{6'h00,  0,  0, 0, 0};
    tab[6] = '{6'h1F,  0, 31, 0, 0};
    tab[7] = '{6'h3F,  0,  1, 1, 0};  // -1
    tab[8] = '{6'h03,  0,  3, 0, 0};
`endif
    rst_n = 1'b0; ena = 1'b1; u = 6'h08;
    rst4_n = 1'b0; ena4 = 1'b1; u4 = 6'h02;

    repeat (3) @(negedge clk);
    chk("reset_pwm", pwm, 0);
    chk("reset_dir", dir, 0);
    chk("reset_period_start", ps, 0);
    chk("reset_sat", sat, 0);

    sb.push_back('{8, 0, 0});
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // First period after reset carries duty 0 and no start pulse.
    hi = 0; psn = 0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      if (pwm === 1'b1) hi++;
      if (ps === 1'b1) psn++;
    end
    chk("first_period_high_clocks", hi, 0);
    chk("first_period_starts", psn, 0);

    for (int i = 0; i < 9; i++) begin
      wait_ps($sformatf("timeout_period_%0d", i));
      repeat (tab[i].off) @(negedge clk);
      u = tab[i].u;
      sb.push_back('{tab[i].duty, tab[i].dir, tab[i].sat});
    end

    // Last scoreboarded period has started; stop scoreboarding after it.
    wait_ps("timeout_last_period");
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    u = 6'h34;  // -12
    wait_ps("timeout_k_period");
    wait_ps("timeout_l_period");   // duty 12, dir 1 in either build
    chk("sb_drained", sb.size(), 0);

    repeat (5) @(negedge clk);     // cnt 5
    chk("l_pwm_at_cnt5", pwm, 1);
    chk("l_dir", dir, 1);
    repeat (12) @(negedge clk);    // cnt 17
    chk("l_pwm_at_cnt17", pwm, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_pwm", pwm, 0);
    chk("midreset_dir", dir, 0);
    chk("midreset_period_start", ps, 0);
    chk("midreset_sat", sat, 0);
    chk("midreset_cnt", int'(dut.u_counter.cnt), 0);
    u = 6'h0C;
    rst_n = 1'b1;

    hi = 0; psn = 0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      if (pwm === 1'b1) hi++;
      if (ps === 1'b1) psn++;
    end
    chk("post_reset_first_high_clocks", hi, 0);
    chk("post_reset_first_starts", psn, 0);
    @(negedge clk);
    chk("post_reset_period_start", ps, 1);
    hi = 0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      if (pwm === 1'b1) hi++;
    end
    chk("post_reset_second_high_clocks", hi, 12);

    // PRESCALE=4, u=+2: ena dropped for 10 clocks after 4 high clocks.
    @(negedge clk);
    rst4_n = 1'b1;
    wait_ps4("timeout_pre4_first");
    begin
      int h4, gap_bad, cnt_bad, ps_bad;
      h4 = 0; gap_bad = 0; cnt_bad = 0; ps_bad = 0;
      for (int k = 0; k < 138; k++) begin
        if (k > 0) @(negedge clk);
        if (pwm4 === 1'b1) h4++;
        if (ps4 !== ((k == 0) ? 1'b1 : 1'b0)) ps_bad++;
        if (k >= 4 && k <= 13) begin
          if (pwm4 !== 1'b0) gap_bad++;
          if (dut4.u_counter.cnt !== 5'd0) cnt_bad++;
        end
        if (k == 3)  ena4 = 1'b0;
        if (k == 13) ena4 = 1'b1;
      end
      chk("pre4_high_clocks", h4, 8);
      chk("pre4_gap_pwm_bad_clocks", gap_bad, 0);
      chk("pre4_gap_cnt_moved_clocks", cnt_bad, 0);
      chk("pre4_period_start_bad_clocks", ps_bad, 0);
      @(negedge clk);
      chk("pre4_next_period_start", ps4, 1);
      chk("pre4_dir", dir4, 0);
      chk("pre4_sat", sat4, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
